unary_add_n: RTL and testbench

Parametrised multi-input unary accumulator, the successor to the two-input 10-bit unary adder. In the accumulate phase it counts the ones on `N_IN` unary input lanes each cycle. In the drain phase it re-emits the accumulated total as a serial unary pulse train on `dout`. It adds a configurable counter width, a wrap-with-carry or saturate overflow mode, a sticky overflow flag, a synchronous clear, and count/empty visibility for the downstream unary pipeline.

---
 rtl/unary_add_n_if.sv | 26 ++
 rtl/unary_add_n.sv | 103 ++++++++++
 tb/tb_unary_add_n.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unary_add_n_if.sv
// Bundle of the control, unary data and status signals of the unary accumulator.
// master drives the phase/enable/lanes; slave (the accumulator) returns the status.
interface unary_add_n_if #(
   parameter int N_IN  = 4,
   parameter int CNT_W = 10
);
   logic             en;
   logic             clr;
   logic             read_or_write;
   logic [N_IN-1:0]  din;
   logic             dout;
   logic             C;
   logic             ovf;
   logic [CNT_W-1:0] count_o;
   logic             empty;

   modport master (
      output en, clr, read_or_write, din,
      input  dout, C, ovf, count_o, empty
   );

   modport slave (
      input  en, clr, read_or_write, din,
      output dout, C, ovf, count_o, empty
   );
endinterface

// File: rtl/unary_add_n.sv
// Multi-lane unary accumulator: counts ones on N_IN lanes while accumulating,
// re-emits the total as a serial unary pulse train while draining.
module unary_add_n #(
   parameter int N_IN     = 4,
   parameter int CNT_W    = 10,
   parameter int SAT_MODE = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   unary_add_n_if.slave bus
);

   localparam int               SUM_W = CNT_W + 1;
   localparam logic [CNT_W-1:0] MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   logic [CNT_W-1:0] count_q, count_d;
   logic             dout_q, dout_d;
   logic             c_q, c_d;
   logic             ovf_q, ovf_d;

   logic [SUM_W-1:0] s;
   logic [SUM_W-1:0] nxt;
   logic [CNT_W-1:0] acc_cnt;
   logic             acc_c;

   function automatic logic [SUM_W-1:0] popcount(input logic [N_IN-1:0] v);
      logic [SUM_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < N_IN; i++) begin
         acc = acc + SUM_W'(v[i]);
      end
      return acc;
   endfunction

   // Returns {carry, count}: anything above MAX pins to MAX with the carry raised.
   function automatic logic [SUM_W-1:0] saturate(input logic [SUM_W-1:0] v);
      if (v > {1'b0, MAX}) begin
         return {1'b1, MAX};
      end
      return v;
   endfunction

   always_comb begin
      s   = popcount(bus.din);
      nxt = {1'b0, count_q} + s;
      if (SAT_MODE != 0) begin
         {acc_c, acc_cnt} = saturate(nxt);
      end else begin
         {acc_c, acc_cnt} = nxt;
      end
   end

   always_comb begin
      count_d = count_q;
      dout_d  = dout_q;
      c_d     = c_q;
      ovf_d   = ovf_q;
      if (bus.clr) begin
         count_d = '0;
         dout_d  = 1'b0;
         c_d     = 1'b0;
         ovf_d   = 1'b0;
      end else if (bus.en) begin
         if (!bus.read_or_write) begin
            count_d = acc_cnt;
            c_d     = acc_c;
            ovf_d   = ovf_q | acc_c;
            dout_d  = 1'b0;
         end else begin
            // Drain never underflows: an empty counter just emits zeros.
            c_d = 1'b0;
            if (count_q != '0) begin
               dout_d  = 1'b1;
               count_d = count_q - ONE;
            end else begin
               dout_d  = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         dout_q  <= 1'b0;
         c_q     <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         dout_q  <= dout_d;
         c_q     <= c_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.dout    = dout_q;
   assign bus.C       = c_q;
   assign bus.ovf     = ovf_q;
   assign bus.count_o = count_q;
   assign bus.empty   = (count_q == '0);

endmodule

// File: tb/tb_unary_add_n.sv
// Scoreboard bench for unary_add_n: wrap, saturate and narrow instances checked
// against a behavioural model, plus directed boundary checks.
module tb_unary_add_n;

   logic clk;
   logic rst_n;
   int   vecs;
   int   miss;

   unary_add_n_if #(.N_IN(4), .CNT_W(10)) if_a ();
   unary_add_n_if #(.N_IN(4), .CNT_W(10)) if_s ();
   unary_add_n_if #(.N_IN(1), .CNT_W(3))  if_n ();

   unary_add_n #(.N_IN(4), .CNT_W(10), .SAT_MODE(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   unary_add_n #(.N_IN(4), .CNT_W(10), .SAT_MODE(1)) u_s (.clk(clk), .rst_n(rst_n), .bus(if_s));
   unary_add_n #(.N_IN(1), .CNT_W(3),  .SAT_MODE(0)) u_n (.clk(clk), .rst_n(rst_n), .bus(if_n));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model state per instance and expected-output queues
   int          ma_cnt, ms_cnt, mn_cnt;
   bit          ma_d, ma_c, ma_o;
   bit          ms_d, ms_c, ms_o;
   bit          mn_d, mn_c, mn_o;
   logic [19:0] q_a[$];
   logic [19:0] q_s[$];
   logic [19:0] q_n[$];

   task automatic model_step(input int cntw, input int sat, input int nin, input logic [15:0] din,
                             input bit en, input bit clr, input bit rw,
                             inout int cnt, inout bit d, inout bit c, inout bit o);
      int maxv;
      int sum;
      int nx;
      maxv = (1 << cntw) - 1;
      sum  = 0;
      for (int i = 0; i < nin; i++) sum += int'(din[i]);
      if (clr) begin
         cnt = 0; d = 0; c = 0; o = 0;
      end else if (en) begin
         if (!rw) begin
            nx = cnt + sum;
            d  = 0;
            c  = (nx > maxv);
            if (sat != 0) cnt = c ? maxv : nx;
            else          cnt = nx % (maxv + 1);
            o  = o | c;
         end else begin
            c = 0;
            if (cnt != 0) begin d = 1; cnt = cnt - 1; end
            else d = 0;
         end
      end
   endtask

   function automatic logic [19:0] pack(input int cnt, input bit d, input bit c, input bit o);
      logic [15:0] c16;
      c16 = cnt[15:0];
      return {d, c, o, (cnt == 0), c16};
   endfunction

   function automatic logic [19:0] act_a();
      return {if_a.dout, if_a.C, if_a.ovf, if_a.empty, 6'b0, if_a.count_o};
   endfunction
   function automatic logic [19:0] act_s();
      return {if_s.dout, if_s.C, if_s.ovf, if_s.empty, 6'b0, if_s.count_o};
   endfunction
   function automatic logic [19:0] act_n();
      return {if_n.dout, if_n.C, if_n.ovf, if_n.empty, 13'b0, if_n.count_o};
   endfunction

   task automatic tick_a(input bit en, input bit clr, input bit rw, input logic [3:0] din);
      if_a.en = en; if_a.clr = clr; if_a.read_or_write = rw; if_a.din = din;
      model_step(10, 0, 4, {12'b0, din}, en, clr, rw, ma_cnt, ma_d, ma_c, ma_o);
      q_a.push_back(pack(ma_cnt, ma_d, ma_c, ma_o));
      @(posedge clk); #1;
   endtask

   task automatic tick_s(input bit en, input bit clr, input bit rw, input logic [3:0] din);
      if_s.en = en; if_s.clr = clr; if_s.read_or_write = rw; if_s.din = din;
      model_step(10, 1, 4, {12'b0, din}, en, clr, rw, ms_cnt, ms_d, ms_c, ms_o);
      q_s.push_back(pack(ms_cnt, ms_d, ms_c, ms_o));
      @(posedge clk); #1;
   endtask

   task automatic tick_n(input bit en, input bit clr, input bit rw, input logic din);
      if_n.en = en; if_n.clr = clr; if_n.read_or_write = rw; if_n.din = din;
      model_step(3, 0, 1, {15'b0, din}, en, clr, rw, mn_cnt, mn_d, mn_c, mn_o);
      q_n.push_back(pack(mn_cnt, mn_d, mn_c, mn_o));
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [19:0] exp, act;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) tick_a(1, 0, 0, 4'b1111);
         else       tick_a(1, 0, 1, 4'b0000);
         exp = q_a.pop_front(); act = act_a(); vecs++;
         if (act !== exp) begin miss++; $display("FAIL reset_pre[%0d]: got %h expected %h", i, act, exp); end
      end
      // mid-drain reset, away from any clock edge
      #3 rst_n = 1'b0;
      #1;
      vecs++;
      if (if_a.dout !== 1'b0) begin miss++; $display("FAIL reset_dout_async: got %b expected 0", if_a.dout); end
      act = act_a(); vecs++;
      if (act !== 20'h10000) begin miss++; $display("FAIL reset_a: got %h expected %h", act, 20'h10000); end
      act = act_s(); vecs++;
      if (act !== 20'h10000) begin miss++; $display("FAIL reset_s: got %h expected %h", act, 20'h10000); end
      act = act_n(); vecs++;
      if (act !== 20'h10000) begin miss++; $display("FAIL reset_n: got %h expected %h", act, 20'h10000); end
      ma_cnt = 0; ma_d = 0; ma_c = 0; ma_o = 0;
      ms_cnt = 0; ms_d = 0; ms_c = 0; ms_o = 0;
      mn_cnt = 0; mn_d = 0; mn_c = 0; mn_o = 0;
      #2 rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick_a(0, 0, 0, 4'b1111);
         exp = q_a.pop_front(); act = act_a(); vecs++;
         if (act !== exp) begin miss++; $display("FAIL reset_hold[%0d]: got %h expected %h", i, act, exp); end
      end
   endtask

   task automatic test_accum_drain();
      logic [19:0] exp, act;
      int ones;
      for (int i = 0; i < 3; i++) begin
         tick_a(1, 0, 0, 4'b1011);
         exp = q_a.pop_front(); act = act_a(); vecs++;
         if (act !== exp) begin miss++; $display("FAIL accum[%0d]: got %h expected %h", i, act, exp); end
         vecs++;
         if (if_a.count_o !== 10'(3 * (i + 1))) begin
            miss++; $display("FAIL accum_count[%0d]: got %0d expected %0d", i, if_a.count_o, 3 * (i + 1));
         end
      end
      ones = 0;
      for (int i = 0; i < 11; i++) begin
         tick_a(1, 0, 1, 4'b0000);
         exp = q_a.pop_front(); act = act_a(); vecs++;
         if (act !== exp) begin miss++; $display("FAIL drain[%0d]: got %h expected %h", i, act, exp); end
         if (if_a.dout === 1'b1) ones++;
         vecs++;
         if (if_a.C !== 1'b0) begin miss++; $display("FAIL drain_c[%0d]: got %b expected 0", i, if_a.C); end
         if (i == 8) begin
            vecs++;
            if (if_a.empty !== 1'b1) begin miss++; $display("FAIL drain_empty: got %b expected 1", if_a.empty); end
         end
      end
      vecs++;
      if (ones != 9) begin miss++; $display("FAIL drain_ones: got %0d expected 9", ones); end
   endtask

   task automatic test_wrap();
      logic [19:0] exp, act;
      tick_a(1, 1, 0, 4'b0000);
      exp = q_a.pop_front(); act = act_a(); vecs++;
      if (act !== exp) begin miss++; $display("FAIL wrap_clr: got %h expected %h", act, exp); end
      for (int i = 0; i < 256; i++) begin
         tick_a(1, 0, 0, (i < 255) ? 4'b1111 : 4'b0011);
         exp = q_a.pop_front(); act = act_a(); vecs++;
         if (act !== exp) begin miss++; $display("FAIL wrap_preload[%0d]: got %h expected %h", i, act, exp); end
      end
      vecs++;
      if (if_a.count_o !== 10'd1022) begin miss++; $display("FAIL wrap_preload_val: got %0d expected 1022", if_a.count_o); end
      tick_a(1, 0, 0, 4'b0111);
      exp = q_a.pop_front(); act = act_a(); vecs++;
      if (act !== exp) begin miss++; $display("FAIL wrap_step: got %h expected %h", act, exp); end
      vecs++;
      if ({if_a.count_o, if_a.C, if_a.ovf} !== {10'd1, 1'b1, 1'b1}) begin
         miss++; $display("FAIL wrap_boundary: got cnt=%0d C=%b ovf=%b expected cnt=1 C=1 ovf=1", if_a.count_o, if_a.C, if_a.ovf);
      end
      for (int i = 0; i < 3; i++) begin
         tick_a(1, 0, 1, 4'b0000);
         exp = q_a.pop_front(); act = act_a(); vecs++;
         if (act !== exp) begin miss++; $display("FAIL wrap_drain[%0d]: got %h expected %h", i, act, exp); end
         vecs++;
         if ({if_a.ovf, if_a.C} !== 2'b10) begin miss++; $display("FAIL wrap_ovf_sticky[%0d]: got ovf=%b C=%b expected ovf=1 C=0", i, if_a.ovf, if_a.C); end
      end
   endtask

   task automatic test_stall_clear();
      logic [19:0] exp, act;
      int ones;
      bit en_v, rw_v;
      logic [3:0] din_v;
      ones = 0;
      // 2 accumulate, 2 drain, 3 stalled, 3 drain, 1 extra drain
      for (int i = 0; i < 11; i++) begin
         en_v = !(i >= 4 && i < 7);
         rw_v = (i >= 2);
         din_v = (i == 0) ? 4'b1111 : (i == 1) ? 4'b0001 : 4'b0000;
         tick_a(en_v, 0, rw_v, din_v);
         exp = q_a.pop_front(); act = act_a(); vecs++;
         if (act !== exp) begin miss++; $display("FAIL stall[%0d]: got %h expected %h", i, act, exp); end
         if (i >= 4 && i < 7) begin
            vecs++;
            if ({if_a.dout, if_a.count_o} !== {1'b1, 10'd3}) begin
               miss++; $display("FAIL stall_hold[%0d]: got dout=%b cnt=%0d expected dout=1 cnt=3", i, if_a.dout, if_a.count_o);
            end
         end
         if (i >= 7 && if_a.dout === 1'b1) ones++;
      end
      vecs++;
      if (ones != 3) begin miss++; $display("FAIL stall_resume_ones: got %0d expected 3", ones); end
      tick_a(1, 0, 0, 4'b1111);
      exp = q_a.pop_front(); act = act_a(); vecs++;
      if (act !== exp) begin miss++; $display("FAIL clr_fill: got %h expected %h", act, exp); end
      for (int i = 0; i < 2; i++) begin
         tick_a(1, 0, 1, 4'b0000);
         exp = q_a.pop_front(); act = act_a(); vecs++;
         if (act !== exp) begin miss++; $display("FAIL clr_drain[%0d]: got %h expected %h", i, act, exp); end
      end
      tick_a(1, 1, 1, 4'b1111);
      exp = q_a.pop_front(); act = act_a(); vecs++;
      if (act !== exp) begin miss++; $display("FAIL clr_mid: got %h expected %h", act, exp); end
      vecs++;
      if ({if_a.count_o, if_a.dout, if_a.ovf, if_a.C} !== 13'd0) begin
         miss++; $display("FAIL clr_zero: got cnt=%0d dout=%b ovf=%b C=%b expected all 0", if_a.count_o, if_a.dout, if_a.ovf, if_a.C);
      end
   endtask

   task automatic test_saturate();
      logic [19:0] exp, act;
      logic [3:0]  seq [3];
      logic [11:0] want [3];
      for (int i = 0; i < 256; i++) begin
         tick_s(1, 0, 0, (i < 255) ? 4'b1111 : 4'b0001);
         exp = q_s.pop_front(); act = act_s(); vecs++;
         if (act !== exp) begin miss++; $display("FAIL sat_preload[%0d]: got %h expected %h", i, act, exp); end
      end
      seq[0] = 4'b1111; seq[1] = 4'b0001; seq[2] = 4'b0000;
      want[0] = {10'd1023, 1'b1, 1'b1};
      want[1] = {10'd1023, 1'b1, 1'b1};
      want[2] = {10'd1023, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         tick_s(1, 0, 0, seq[i]);
         exp = q_s.pop_front(); act = act_s(); vecs++;
         if (act !== exp) begin miss++; $display("FAIL sat_step[%0d]: got %h expected %h", i, act, exp); end
         vecs++;
         if ({if_s.count_o, if_s.C, if_s.ovf} !== want[i]) begin
            miss++; $display("FAIL sat_boundary[%0d]: got cnt=%0d C=%b ovf=%b expected %h", i, if_s.count_o, if_s.C, if_s.ovf, want[i]);
         end
      end
   endtask

   task automatic test_narrow();
      logic [19:0] exp, act;
      int ones;
      for (int i = 0; i < 9; i++) begin
         tick_n(1, 0, 0, 1'b1);
         exp = q_n.pop_front(); act = act_n(); vecs++;
         if (act !== exp) begin miss++; $display("FAIL narrow[%0d]: got %h expected %h", i, act, exp); end
         if (i == 7) begin
            vecs++;
            if ({if_n.count_o, if_n.C} !== {3'd0, 1'b1}) begin miss++; $display("FAIL narrow_wrap: got cnt=%0d C=%b expected cnt=0 C=1", if_n.count_o, if_n.C); end
         end
      end
      vecs++;
      if ({if_n.count_o, if_n.C} !== {3'd1, 1'b0}) begin miss++; $display("FAIL narrow_after: got cnt=%0d C=%b expected cnt=1 C=0", if_n.count_o, if_n.C); end
      ones = 0;
      for (int i = 0; i < 3; i++) begin
         tick_n(1, 0, 1, 1'b0);
         exp = q_n.pop_front(); act = act_n(); vecs++;
         if (act !== exp) begin miss++; $display("FAIL narrow_drain[%0d]: got %h expected %h", i, act, exp); end
         if (if_n.dout === 1'b1) ones++;
      end
      vecs++;
      if (ones != 1) begin miss++; $display("FAIL narrow_ones: got %0d expected 1", ones); end
   endtask

   task automatic test_back_to_back();
      logic [19:0] exp, act;
      bit ph_a, ph_s;
      ph_a = 0; ph_s = 0;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(9) == 0) ph_a = !ph_a;
         tick_a($urandom_range(7) != 0, $urandom_range(59) == 0, ph_a, 4'($urandom));
         exp = q_a.pop_front(); act = act_a(); vecs++;
         if (act !== exp) begin miss++; $display("FAIL b2b_wrap[%0d]: got %h expected %h", i, act, exp); end
      end
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(11) == 0) ph_s = !ph_s;
         tick_s($urandom_range(7) != 0, $urandom_range(199) == 0, ph_s, 4'($urandom));
         exp = q_s.pop_front(); act = act_s(); vecs++;
         if (act !== exp) begin miss++; $display("FAIL b2b_sat[%0d]: got %h expected %h", i, act, exp); end
      end
   endtask

   initial begin
      vecs = 0; miss = 0;
      ma_cnt = 0; ma_d = 0; ma_c = 0; ma_o = 0;
      ms_cnt = 0; ms_d = 0; ms_c = 0; ms_o = 0;
      mn_cnt = 0; mn_d = 0; mn_c = 0; mn_o = 0;
      if_a.en = 0; if_a.clr = 0; if_a.read_or_write = 0; if_a.din = '0;
      if_s.en = 0; if_s.clr = 0; if_s.read_or_write = 0; if_s.din = '0;
      if_n.en = 0; if_n.clr = 0; if_n.read_or_write = 0; if_n.din = '0;
      rst_n = 1'b0;
      #12 rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_accum_drain();
      test_wrap();
      test_stall_clear();
      test_saturate();
      test_narrow();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
